// File: rtl/seven_seg_pkg.sv
// Segment patterns (bit0=a .. bit6=g, active-high) shared by the 7-segment scanner
// and its decoder.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] seg_pattern(input logic [3:0] nibble);
    logic [6:0] pat;
    case (nibble)
      4'h0:    pat = SEG_0;
      4'h1:    pat = SEG_1;
      4'h2:    pat = SEG_2;
      4'h3:    pat = SEG_3;
      4'h4:    pat = SEG_4;
      4'h5:    pat = SEG_5;
      4'h6:    pat = SEG_6;
      4'h7:    pat = SEG_7;
      4'h8:    pat = SEG_8;
      4'h9:    pat = SEG_9;
      4'hA:    pat = SEG_A;
      4'hB:    pat = SEG_B;
      4'hC:    pat = SEG_C;
      4'hD:    pat = SEG_D;
      4'hE:    pat = SEG_E;
      default: pat = SEG_F;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational nibble -> 7-segment decoder (active-high).
// Define HEX_DECODE_EN to show A..F for nibbles 10..15; otherwise they are blank.
module seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
`ifdef HEX_DECODE_EN
    seg_o = seg_pattern(nibble_i);
`else
    seg_o = (nibble_i > 4'd9) ? SEG_BLANK : seg_pattern(nibble_i);
`endif
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed N-digit 7-segment scanner with frame latching, leading-zero blanking and
// anti-ghosting dead time. Optional macro HEX_DECODE_EN (in seg_decoder) enables A..F glyphs.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int REFRESH_DIV    = 100000,
  parameter int BLANK_CYCLES   = 1000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] digits_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic                  lzb_i,
  input  logic                  en_i,
  output logic [N_DIGITS-1:0]   an_o,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic                  frame_o
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CNT_W-1:0]    CNT_MAX     = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]    BLANK_START = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]    IDX_MAX     = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_OFF      = (AN_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};
  localparam logic [6:0]          SEG_OFF     = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                DP_OFF      = (SEG_ACTIVE_LOW != 0);

  logic [CNT_W-1:0]      cnt_d, cnt_q;
  logic [IDX_W-1:0]      idx_d, idx_q;
  logic [4*N_DIGITS-1:0] frame_digits_d, frame_digits_q;
  logic [N_DIGITS-1:0]   frame_dp_d, frame_dp_q;
  logic                  frame_lzb_d, frame_lzb_q;
  logic                  frame_d, frame_q;
  logic [N_DIGITS-1:0]   an_d, an_q;
  logic [6:0]            seg_d, seg_q;
  logic                  dp_d, dp_q;

  logic                  latch;
  logic                  show;
  logic                  above_zero;
  logic [3:0]            cur_nibble;
  logic                  cur_dp;
  logic                  cur_blank;
  logic [N_DIGITS-1:0]   an_onehot;
  logic [6:0]            dec_seg;
  logic [N_DIGITS-1:0]   an_act;
  logic [6:0]            seg_act;
  logic                  dp_act;

  seg_decoder u_seg_decoder (
    .nibble_i (cur_nibble),
    .seg_o    (dec_seg)
  );

  // Scan counters and frame latch; the display reads the *_d frame so the
  // first slot of a frame already shows the freshly latched value.
  always_comb begin
    latch = (cnt_q == '0) && (idx_q == '0);
    cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_MAX) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
    frame_digits_d = latch ? digits_i : frame_digits_q;
    frame_dp_d     = latch ? dp_i     : frame_dp_q;
    frame_lzb_d    = latch ? lzb_i    : frame_lzb_q;
    frame_d        = latch;
  end

  // Walk from the most significant digit down so above_zero tracks "this digit
  // and everything above it is zero" for the leading-zero mask.
  always_comb begin
    cur_nibble = '0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    an_onehot  = '0;
    above_zero = frame_lzb_d;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      above_zero = above_zero && (frame_digits_d[4*k +: 4] == 4'h0);
      if (idx_q == IDX_W'(k)) begin
        cur_nibble   = frame_digits_d[4*k +: 4];
        cur_dp       = frame_dp_d[k];
        cur_blank    = above_zero && (k != 0);
        an_onehot[k] = 1'b1;
      end
    end
  end

  always_comb begin
    show    = en_i && (cnt_q >= BLANK_START);
    an_act  = show ? an_onehot : '0;
    seg_act = (show && !cur_blank) ? dec_seg : SEG_BLANK;
    dp_act  = show && cur_dp;
    an_d    = (AN_ACTIVE_LOW != 0)  ? ~an_act  : an_act;
    seg_d   = (SEG_ACTIVE_LOW != 0) ? ~seg_act : seg_act;
    dp_d    = (SEG_ACTIVE_LOW != 0) ? ~dp_act  : dp_act;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q          <= '0;
      idx_q          <= '0;
      frame_digits_q <= '0;
      frame_dp_q     <= '0;
      frame_lzb_q    <= 1'b0;
      frame_q        <= 1'b0;
      an_q           <= AN_OFF;
      seg_q          <= SEG_OFF;
      dp_q           <= DP_OFF;
    end else begin
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      frame_digits_q <= frame_digits_d;
      frame_dp_q     <= frame_dp_d;
      frame_lzb_q    <= frame_lzb_d;
      frame_q        <= frame_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
    end
  end

  assign an_o    = an_q;
  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner (4 digits, 4-cycle slots, 1 dead cycle,
// active-low outputs); a cycle model pushes expected outputs into a scoreboard queue.
`timescale 1ns/1ps
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digits_i;
  logic [3:0]  dp_i;
  logic        lzb_i;
  logic        en_i;
  logic [3:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic        frame_o;

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fr;
  } exp_t;

  exp_t       sb_q[$];
  logic [6:0] seg_tab [16];

  int          m_cnt;
  int          m_idx;
  logic [15:0] m_digits;
  logic [3:0]  m_dp;
  logic        m_lzb;

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .N_DIGITS       (4),
    .REFRESH_DIV    (4),
    .BLANK_CYCLES   (1),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .digits_i (digits_i),
    .dp_i     (dp_i),
    .lzb_i    (lzb_i),
    .en_i     (en_i),
    .an_o     (an_o),
    .seg_o    (seg_o),
    .dp_o     (dp_o),
    .frame_o  (frame_o)
  );

  // Predict what the outputs will hold after the coming rising edge.
  task automatic model_push();
    exp_t       e;
    logic [3:0] nib;
    logic       lz;
    e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fr: 1'b0};
    if (reset) begin
      m_cnt    = 0;
      m_idx    = 0;
      m_digits = '0;
      m_dp     = '0;
      m_lzb    = 1'b0;
    end else begin
      if (m_cnt == 0 && m_idx == 0) begin
        m_digits = digits_i;
        m_dp     = dp_i;
        m_lzb    = lzb_i;
        e.fr     = 1'b1;
      end
      if (en_i && m_cnt >= 1) begin
        e.an  = ~(4'b0001 << m_idx);
        nib   = m_digits[4*m_idx +: 4];
        lz    = m_lzb && (m_idx != 0) && ((m_digits >> (4*m_idx)) == 16'h0000);
        e.seg = lz ? 7'h7F : ~seg_tab[nib];
        e.dp  = ~m_dp[m_idx];
      end
      m_cnt++;
      if (m_cnt == 4) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % 4;
      end
    end
    sb_q.push_back(e);
  endtask

  task automatic tick();
    model_push();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t e;
    int   pulses;
    int   first;
    reset    = 1'b1;
    digits_i = '0;
    dp_i     = '0;
    lzb_i    = 1'b0;
    en_i     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      e = sb_q.pop_front();
      checks++;
      if ({an_o, seg_o, dp_o, frame_o} !== e)
        $display("[TB] FAIL reset cyc %0d: got an=%b seg=%h dp=%b fr=%b, want an=%b seg=%h dp=%b fr=%b",
                 i, an_o, seg_o, dp_o, frame_o, e.an, e.seg, e.dp, e.fr);
      else passed++;
    end
    reset  = 1'b0;
    pulses = 0;
    first  = -1;
    for (int i = 0; i < 16; i++) begin
      tick();
      e = sb_q.pop_front();
      checks++;
      if ({an_o, seg_o, dp_o, frame_o} !== e)
        $display("[TB] FAIL post_reset cyc %0d: got an=%b seg=%h dp=%b fr=%b, want an=%b seg=%h dp=%b fr=%b",
                 i, an_o, seg_o, dp_o, frame_o, e.an, e.seg, e.dp, e.fr);
      else passed++;
      if (frame_o === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (pulses !== 1 || first !== 0)
      $display("[TB] FAIL first_frame: got %0d pulses first at %0d, want 1 pulse at 0", pulses, first);
    else passed++;
  endtask

  task automatic test_scan();
    exp_t e;
    digits_i = 16'h1234;
    dp_i     = 4'b0100;
    for (int i = 0; i < 32; i++) begin
      tick();
      e = sb_q.pop_front();
      checks++;
      if ({an_o, seg_o, dp_o, frame_o} !== e)
        $display("[TB] FAIL scan cyc %0d: got an=%b seg=%h dp=%b fr=%b, want an=%b seg=%h dp=%b fr=%b",
                 i, an_o, seg_o, dp_o, frame_o, e.an, e.seg, e.dp, e.fr);
      else passed++;
      if (i == 1) begin
        checks++;
        if ({an_o, seg_o, dp_o} !== {4'b1110, ~7'h66, 1'b1})
          $display("[TB] FAIL scan_digit0: got an=%b seg=%h dp=%b, want an=1110 seg=19 dp=1", an_o, seg_o, dp_o);
        else passed++;
      end
      if (i == 9) begin
        checks++;
        if ({an_o, seg_o, dp_o} !== {4'b1011, ~7'h5B, 1'b0})
          $display("[TB] FAIL scan_digit2_dp: got an=%b seg=%h dp=%b, want an=1011 seg=24 dp=0", an_o, seg_o, dp_o);
        else passed++;
      end
    end
  endtask

  task automatic test_lzb();
    exp_t e;
    lzb_i    = 1'b1;
    dp_i     = 4'b0000;
    digits_i = 16'h0050;
    for (int i = 0; i < 64; i++) begin
      if (i == 32) digits_i = 16'h0000;
      tick();
      e = sb_q.pop_front();
      checks++;
      if ({an_o, seg_o, dp_o, frame_o} !== e)
        $display("[TB] FAIL lzb cyc %0d: got an=%b seg=%h dp=%b fr=%b, want an=%b seg=%h dp=%b fr=%b",
                 i, an_o, seg_o, dp_o, frame_o, e.an, e.seg, e.dp, e.fr);
      else passed++;
      if (i == 9) begin
        checks++;
        if ({an_o, seg_o} !== {4'b1011, 7'h7F})
          $display("[TB] FAIL lzb_digit2_blank: got an=%b seg=%h, want an=1011 seg=7f", an_o, seg_o);
        else passed++;
      end
    end
    lzb_i = 1'b0;
  endtask

  task automatic test_no_tearing();
    exp_t e;
    digits_i = 16'h1111;
    dp_i     = 4'b0000;
    for (int i = 0; i < 48; i++) begin
      if (i == 24) begin
        digits_i = 16'h9999;
        dp_i     = 4'b1111;
      end
      tick();
      e = sb_q.pop_front();
      checks++;
      if ({an_o, seg_o, dp_o, frame_o} !== e)
        $display("[TB] FAIL no_tearing cyc %0d: got an=%b seg=%h dp=%b fr=%b, want an=%b seg=%h dp=%b fr=%b",
                 i, an_o, seg_o, dp_o, frame_o, e.an, e.seg, e.dp, e.fr);
      else passed++;
    end
  endtask

  task automatic test_hex();
    exp_t       e;
    logic [6:0] want_a;
`ifdef HEX_DECODE_EN
    want_a = ~7'h77;
`else
    want_a = 7'h7F;
`endif
    digits_i = 16'h000A;
    dp_i     = 4'b0000;
    for (int i = 0; i < 16; i++) begin
      tick();
      e = sb_q.pop_front();
      checks++;
      if ({an_o, seg_o, dp_o, frame_o} !== e)
        $display("[TB] FAIL hex cyc %0d: got an=%b seg=%h dp=%b fr=%b, want an=%b seg=%h dp=%b fr=%b",
                 i, an_o, seg_o, dp_o, frame_o, e.an, e.seg, e.dp, e.fr);
      else passed++;
      if (i == 2) begin
        checks++;
        if ({an_o, seg_o} !== {4'b1110, want_a})
          $display("[TB] FAIL hex_digitA: got an=%b seg=%h, want an=1110 seg=%h", an_o, seg_o, want_a);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    exp_t e;
    int   pulses;
    int   lit;
    digits_i = 16'h8765;
    for (int i = 0; i < 10; i++) begin
      tick();
      e = sb_q.pop_front();
      checks++;
      if ({an_o, seg_o, dp_o, frame_o} !== e)
        $display("[TB] FAIL pre_reset cyc %0d: got an=%b seg=%h dp=%b fr=%b, want an=%b seg=%h dp=%b fr=%b",
                 i, an_o, seg_o, dp_o, frame_o, e.an, e.seg, e.dp, e.fr);
      else passed++;
    end
    reset = 1'b1;
    tick();
    e = sb_q.pop_front();
    checks++;
    if ({an_o, seg_o, dp_o, frame_o} !== e)
      $display("[TB] FAIL mid_reset: got an=%b seg=%h dp=%b fr=%b, want an=%b seg=%h dp=%b fr=%b",
               an_o, seg_o, dp_o, frame_o, e.an, e.seg, e.dp, e.fr);
    else passed++;
    reset  = 1'b0;
    en_i   = 1'b0;
    pulses = 0;
    lit    = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      e = sb_q.pop_front();
      checks++;
      if ({an_o, seg_o, dp_o, frame_o} !== e)
        $display("[TB] FAIL disabled cyc %0d: got an=%b seg=%h dp=%b fr=%b, want an=%b seg=%h dp=%b fr=%b",
                 i, an_o, seg_o, dp_o, frame_o, e.an, e.seg, e.dp, e.fr);
      else passed++;
      if (frame_o === 1'b1) pulses++;
      if (an_o !== 4'hF) lit++;
    end
    checks++;
    if (pulses !== 2 || lit !== 0)
      $display("[TB] FAIL disabled_frames: got %0d pulses %0d lit cycles, want 2 pulses 0 lit", pulses, lit);
    else passed++;
    en_i = 1'b1;
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [15:0] mask;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 2))
        0:       mask = 16'h000F;
        1:       mask = 16'h00FF;
        default: mask = 16'hFFFF;
      endcase
      digits_i = 16'($urandom) & mask;
      dp_i     = 4'($urandom_range(0, 15));
      lzb_i    = 1'($urandom_range(0, 1));
      en_i     = ($urandom_range(0, 9) != 0);
      reset    = ($urandom_range(0, 99) == 0);
      tick();
      e = sb_q.pop_front();
      checks++;
      if ({an_o, seg_o, dp_o, frame_o} !== e)
        $display("[TB] FAIL random cyc %0d: got an=%b seg=%h dp=%b fr=%b, want an=%b seg=%h dp=%b fr=%b",
                 i, an_o, seg_o, dp_o, frame_o, e.an, e.seg, e.dp, e.fr);
      else passed++;
    end
    reset = 1'b0;
  endtask

  initial begin
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
`ifdef HEX_DECODE_EN
    seg_tab[10] = 7'h77;
    seg_tab[11] = 7'h7C;
    seg_tab[12] = 7'h39;
    seg_tab[13] = 7'h5E;
    seg_tab[14] = 7'h79;
    seg_tab[15] = 7'h71;
`endif
    m_cnt    = 0;
    m_idx    = 0;
    m_digits = '0;
    m_dp     = '0;
    m_lzb    = 1'b0;
    reset    = 1'b1;
    digits_i = '0;
    dp_i     = '0;
    lzb_i    = 1'b0;
    en_i     = 1'b1;
    @(negedge clk);
    test_reset();
    test_scan();
    test_lzb();
    test_no_tearing();
    test_hex();
    test_reset_mid_scan();
    test_back_to_back();
    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
